load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the control unit.
- Consumes the decoded load/store type from the control unit, the ALU-computed effective address, and the rs2 store data.
- Runs one data-memory transaction over a request/ready/response bus, then returns sign- or zero-extended load data for REG_WRITE_DMEM writeback.
- Stalls the core until the access completes.

Parameters:
- ADDR_WIDTH, 32, byte-address width of i_Addr and o_Mem_Addr.
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ plus WAIT_RESP before a bus error is flagged; must be 1..65535.

Ports:
- i_Clk  input  1  system clock, rising-edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Valid  input  1  instruction in this stage is valid (control-unit enable).
- i_Load_Store_Type  input  LS_SEL_WIDTH+1  LS_TYPE_* code from memory.vh.
- i_Addr  input  ADDR_WIDTH  effective byte address.
- i_Store_Data  input  32  rs2 value.
- o_Stall  output  1  hold the pipeline/PC.
- o_Done  output  1  one-cycle completion pulse.
- o_Load_Data  output  32  extended load result, valid while o_Done=1.
- o_Misaligned  output  1  alignment fault, pulses with o_Done.
- o_Bus_Error  output  1  timeout fault, pulses with o_Done.
- o_Mem_Req  output  1  bus request.
- o_Mem_We  output  1  1 = write.
- o_Mem_Addr  output  ADDR_WIDTH  word-aligned address, with [1:0] = 0.
- o_Mem_Byte_En  output  4  byte-lane strobes.
- o_Mem_Wdata  output  32  lane-replicated write data.
- i_Mem_Ready  input  1  request accepted this cycle.
- i_Mem_Rvalid  input  1  read data valid.
- i_Mem_Rdata  input  32  read word.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE.
  - All outputs are 0.
  - Timeout counter and latched fields are 0.
  - An outstanding request is dropped immediately; a late i_Mem_Rvalid after reset is ignored.
- States: IDLE, REQ, WAIT_RESP, DONE (registered).
- IDLE, on i_Valid=1 and type != LS_TYPE_NONE:
  - Alignment check: half types need addr[0]=0; word types need addr[1:0]=00; byte types are always aligned.
  - If misaligned: go to DONE with the misaligned flag set; no bus request.
  - Otherwise latch type, addr[1:0], word address, byte enables and write data, clear the counter, and go to REQ.
- Byte enables and write data:
  - SB: BE = 0001 << addr[1:0]; Wdata = byte replicated x4.
  - SH: BE = 0011 << (2*addr[1]); Wdata = half replicated x2.
  - SW: BE = 1111; Wdata = i_Store_Data.
  - Loads: BE = 1111, We = 0.
- REQ:
  - o_Mem_Req=1; Addr, We, BE and Wdata are registered and stable until accepted.
  - On i_Mem_Ready=1: a store goes to DONE; a load goes to WAIT_RESP.
  - i_Mem_Rvalid is ignored in REQ; the response is always at least one cycle after acceptance.
- WAIT_RESP:
  - o_Mem_Req=0.
  - On i_Mem_Rvalid=1, select the lane by latched addr[1:0], extend, latch into o_Load_Data, and go to DONE.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Timeout:
  - The counter increments each cycle in REQ or WAIT_RESP.
  - When it equals TIMEOUT_CYCLES-1 and the awaited event is absent, go to DONE with the bus-error flag set, o_Load_Data=0 and o_Mem_Req=0.
  - If ready/rvalid arrives on that same cycle, normal completion wins.
- DONE:
  - o_Done=1 for exactly one cycle; o_Misaligned and o_Bus_Error reflect the flags.
  - Next state is IDLE and the flags clear.
  - o_Load_Data holds its value until the next load's DONE; it is 0 after stores.
- o_Stall:
  - Combinational: 1 when in IDLE with a qualifying request, and throughout REQ and WAIT_RESP.
  - 0 in DONE, so the instruction retires on the o_Done cycle.
  - 0 in IDLE when there is no request.
- Input handling: inputs are sampled only in IDLE; i_Valid in other states is ignored, since the stalled core holds its inputs.
- Latency:
  - Store: 1 (IDLE) + REQ cycles + 1 (DONE).
  - Load: additionally the WAIT_RESP cycles.
  - Minimum 3 cycles for a store and 4 for a load with zero-wait memory.

Test Plan:
- SW at 0x100, data 0xDEADBEEF, i_Mem_Ready asserted on the 3rd REQ cycle:
  - o_Mem_Req is high for 3 cycles with Addr 0x100, BE 1111, Wdata 0xDEADBEEF, We 1.
  - o_Done follows the next cycle; o_Stall drops on the o_Done cycle.
- SB at 0x103, data 0x000000A5, zero-wait:
  - o_Mem_Addr 0x100, BE 1000, Wdata 0xA5A5A5A5.
- LB at 0x102, Rdata 0x1280FF00:
  - o_Load_Data 0xFFFFFF80.
  - Repeated as LBU: 0x00000080. LH at 0x102: 0x00001280.
- LH at 0x101:
  - No o_Mem_Req.
  - o_Done and o_Misaligned both high 1 cycle after the request.
- TIMEOUT_CYCLES=8, LW with i_Mem_Ready held low:
  - o_Bus_Error and o_Done after 8 REQ cycles; o_Load_Data 0.
  - A ready arriving exactly on the 8th cycle completes normally instead.
- Reset asserted mid-WAIT_RESP:
  - Outputs go to 0 asynchronously; a late Rvalid is ignored.
  - A following SW at 0x200 completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Memory-access stage. Takes a decoded load/store type, the
//             effective byte address and rs2 store data, runs one data-memory
//             transaction on a req/ready/rvalid bus and returns the extended
//             load result. Holds the pipeline until the access completes.
//  Ports    : i_Clk, i_Reset            clock / async active-high reset
//             i_Valid, i_Load_Store_Type, i_Addr, i_Store_Data   request
//             o_Stall, o_Done, o_Load_Data, o_Misaligned, o_Bus_Error
//                                        pipeline-side status and result
//             o_Mem_Req, o_Mem_We, o_Mem_Addr, o_Mem_Byte_En, o_Mem_Wdata,
//             i_Mem_Ready, i_Mem_Rvalid, i_Mem_Rdata    data-memory bus
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int LS_SEL_WIDTH  = 3
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic                    i_Valid,
    input  logic [LS_SEL_WIDTH:0]   i_Load_Store_Type,
    input  logic [ADDR_WIDTH-1:0]   i_Addr,
    input  logic [31:0]             i_Store_Data,
    output logic                    o_Stall,
    output logic                    o_Done,
    output logic [31:0]             o_Load_Data,
    output logic                    o_Misaligned,
    output logic                    o_Bus_Error,
    output logic                    o_Mem_Req,
    output logic                    o_Mem_We,
    output logic [ADDR_WIDTH-1:0]   o_Mem_Addr,
    output logic [3:0]              o_Mem_Byte_En,
    output logic [31:0]             o_Mem_Wdata,
    input  logic                    i_Mem_Ready,
    input  logic                    i_Mem_Rvalid,
    input  logic [31:0]             i_Mem_Rdata
);

    // Load/store type codes (bit 3 marks a store).
    localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_NONE = 4'b0000;
    localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_LB   = 4'b0001;
    localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_LH   = 4'b0010;
    localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_LW   = 4'b0011;
    localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_LBU  = 4'b0101;
    localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_LHU  = 4'b0110;
    localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_SB   = 4'b1001;
    localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_SH   = 4'b1010;
    localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_SW   = 4'b1011;

    localparam logic [1:0] c_SIZE_B = 2'd0;
    localparam logic [1:0] c_SIZE_H = 2'd1;
    localparam logic [1:0] c_SIZE_W = 2'd2;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_REQ       = 2'd1;
    localparam logic [1:0] c_ST_WAIT_RESP = 2'd2;
    localparam logic [1:0] c_ST_DONE      = 2'd3;

    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]              r_state;
    logic [LS_SEL_WIDTH:0]   r_type;
    logic [1:0]              r_offset;
    logic [15:0]             r_timer;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [3:0]              r_mem_be;
    logic [31:0]             r_mem_wdata;
    logic [31:0]             r_load_data;
    logic                    r_misaligned;
    logic                    r_bus_error;

    logic                    w_is_load;
    logic                    w_is_store;
    logic [1:0]              w_size;
    logic                    w_request;
    logic                    w_misaligned;
    logic [3:0]              w_be;
    logic [31:0]             w_wdata;
    logic                    w_timeout;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_load_ext;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = c_SIZE_W;
        case (i_Load_Store_Type)
            c_LS_TYPE_LB, c_LS_TYPE_LBU: begin w_is_load  = 1'b1; w_size = c_SIZE_B; end
            c_LS_TYPE_LH, c_LS_TYPE_LHU: begin w_is_load  = 1'b1; w_size = c_SIZE_H; end
            c_LS_TYPE_LW:                begin w_is_load  = 1'b1; w_size = c_SIZE_W; end
            c_LS_TYPE_SB:                begin w_is_store = 1'b1; w_size = c_SIZE_B; end
            c_LS_TYPE_SH:                begin w_is_store = 1'b1; w_size = c_SIZE_H; end
            c_LS_TYPE_SW:                begin w_is_store = 1'b1; w_size = c_SIZE_W; end
            default:                     begin w_is_load  = 1'b0; w_is_store = 1'b0; end
        endcase
    end

    // Unrecognised codes (including NONE) are treated as no request.
    assign w_request    = i_Valid & (w_is_load | w_is_store);
    assign w_misaligned = ((w_size == c_SIZE_H) &  i_Addr[0]) |
                          ((w_size == c_SIZE_W) & (i_Addr[1:0] != 2'b00));

    // Lane strobes and replicated write data, so the memory can pick its
    // lane purely from the byte enables.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'd0;
        if (w_is_store) begin
            case (w_size)
                c_SIZE_B: begin
                    w_be    = 4'b0001 << i_Addr[1:0];
                    w_wdata = {4{i_Store_Data[7:0]}};
                end
                c_SIZE_H: begin
                    w_be    = i_Addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{i_Store_Data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = i_Store_Data;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load lane selection and extension
    // ------------------------------------------------------------------
    always_comb begin
        case (r_offset)
            2'd0:    w_byte = i_Mem_Rdata[7:0];
            2'd1:    w_byte = i_Mem_Rdata[15:8];
            2'd2:    w_byte = i_Mem_Rdata[23:16];
            default: w_byte = i_Mem_Rdata[31:24];
        endcase
        w_half = r_offset[1] ? i_Mem_Rdata[31:16] : i_Mem_Rdata[15:0];
        case (r_type)
            c_LS_TYPE_LB:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            c_LS_TYPE_LBU: w_load_ext = {24'd0, w_byte};
            c_LS_TYPE_LH:  w_load_ext = {{16{w_half[15]}}, w_half};
            c_LS_TYPE_LHU: w_load_ext = {16'd0, w_half};
            default:       w_load_ext = i_Mem_Rdata;
        endcase
    end

    // The timer spans REQ and WAIT_RESP together. ">=" rather than "=="
    // keeps the budget honest when acceptance lands on the final cycle and
    // the timer has already moved past the limit while awaiting rvalid.
    assign w_timeout = (r_timer >= c_TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state      <= c_ST_IDLE;
            r_type       <= c_LS_TYPE_NONE;
            r_offset     <= 2'd0;
            r_timer      <= 16'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= 4'd0;
            r_mem_wdata  <= 32'd0;
            r_load_data  <= 32'd0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_request) begin
                        if (w_misaligned) begin
                            r_misaligned <= 1'b1;
                            r_load_data  <= 32'd0;
                            r_state      <= c_ST_DONE;
                        end else begin
                            r_type      <= i_Load_Store_Type;
                            r_offset    <= i_Addr[1:0];
                            r_mem_addr  <= {i_Addr[ADDR_WIDTH-1:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                            r_mem_we    <= w_is_store;
                            r_mem_req   <= 1'b1;
                            r_timer     <= 16'd0;
                            r_state     <= c_ST_REQ;
                        end
                    end
                end
                c_ST_REQ: begin
                    r_timer <= r_timer + 16'd1;
                    if (i_Mem_Ready) begin
                        r_mem_req <= 1'b0;
                        if (r_mem_we) begin
                            r_load_data <= 32'd0;
                            r_state     <= c_ST_DONE;
                        end else begin
                            r_state <= c_ST_WAIT_RESP;
                        end
                    end else if (w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_load_data <= 32'd0;
                        r_state     <= c_ST_DONE;
                    end
                end
                c_ST_WAIT_RESP: begin
                    r_timer <= r_timer + 16'd1;
                    if (i_Mem_Rvalid) begin
                        r_load_data <= w_load_ext;
                        r_state     <= c_ST_DONE;
                    end else if (w_timeout) begin
                        r_bus_error <= 1'b1;
                        r_load_data <= 32'd0;
                        r_state     <= c_ST_DONE;
                    end
                end
                default: begin
                    r_misaligned <= 1'b0;
                    r_bus_error  <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the first IDLE cycle of a request already
    // holds the PC; it drops in DONE so the instruction retires with o_Done.
    assign o_Stall = ~i_Reset &
                     (((r_state == c_ST_IDLE) & w_request) |
                      (r_state == c_ST_REQ) |
                      (r_state == c_ST_WAIT_RESP));

    assign o_Done        = (r_state == c_ST_DONE);
    assign o_Load_Data   = r_load_data;
    assign o_Misaligned  = r_misaligned;
    assign o_Bus_Error   = r_bus_error;
    assign o_Mem_Req     = r_mem_req;
    assign o_Mem_We      = r_mem_we;
    assign o_Mem_Addr    = r_mem_addr;
    assign o_Mem_Byte_En = r_mem_be;
    assign o_Mem_Wdata   = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Self-checking bench for load_store_unit (TIMEOUT_CYCLES = 8).
//             Table of access vectors driven through a small bus responder,
//             with expected completions queued and popped on o_Done, plus
//             hand-written reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    localparam logic [3:0] c_NONE = 4'b0000;
    localparam logic [3:0] c_LB   = 4'b0001;
    localparam logic [3:0] c_LH   = 4'b0010;
    localparam logic [3:0] c_LW   = 4'b0011;
    localparam logic [3:0] c_LBU  = 4'b0101;
    localparam logic [3:0] c_LHU  = 4'b0110;
    localparam logic [3:0] c_SB   = 4'b1001;
    localparam logic [3:0] c_SH   = 4'b1010;
    localparam logic [3:0] c_SW   = 4'b1011;
    localparam int         c_NVEC = 15;

    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic        i_Valid;
    logic [3:0]  i_Load_Store_Type;
    logic [31:0] i_Addr;
    logic [31:0] i_Store_Data;
    logic        o_Stall;
    logic        o_Done;
    logic [31:0] o_Load_Data;
    logic        o_Misaligned;
    logic        o_Bus_Error;
    logic        o_Mem_Req;
    logic        o_Mem_We;
    logic [31:0] o_Mem_Addr;
    logic [3:0]  o_Mem_Byte_En;
    logic [31:0] o_Mem_Wdata;
    logic        i_Mem_Ready;
    logic        i_Mem_Rvalid;
    logic [31:0] i_Mem_Rdata;

    always #5 i_Clk = ~i_Clk;

    load_store_unit #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_Clk             (i_Clk),
        .i_Reset           (i_Reset),
        .i_Valid           (i_Valid),
        .i_Load_Store_Type (i_Load_Store_Type),
        .i_Addr            (i_Addr),
        .i_Store_Data      (i_Store_Data),
        .o_Stall           (o_Stall),
        .o_Done            (o_Done),
        .o_Load_Data       (o_Load_Data),
        .o_Misaligned      (o_Misaligned),
        .o_Bus_Error       (o_Bus_Error),
        .o_Mem_Req         (o_Mem_Req),
        .o_Mem_We          (o_Mem_We),
        .o_Mem_Addr        (o_Mem_Addr),
        .o_Mem_Byte_En     (o_Mem_Byte_En),
        .o_Mem_Wdata       (o_Mem_Wdata),
        .i_Mem_Ready       (i_Mem_Ready),
        .i_Mem_Rvalid      (i_Mem_Rvalid),
        .i_Mem_Rdata       (i_Mem_Rdata)
    );

    typedef struct {
        logic [3:0]  ls_type;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ready_wait;   // REQ cycles before ready is given
        int          rvalid_wait;  // WAIT_RESP cycles before rvalid is given
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_we;
        int          exp_req_cycles;
        int          exp_cycles;   // cycles from request until o_Done
        logic [31:0] exp_load;
        logic        exp_mis;
        logic        exp_berr;
    } vec_t;

    vec_t vecs[c_NVEC];
    vec_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] t, input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rd, input int rw, input int rvw,
                                input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                                input logic ewe, input int ereq, input int ecyc,
                                input logic [31:0] eld, input logic emis, input logic eberr);
        vec_t v;
        v.ls_type = t; v.addr = a; v.sdata = sd; v.rdata = rd;
        v.ready_wait = rw; v.rvalid_wait = rvw;
        v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ewd; v.exp_we = ewe;
        v.exp_req_cycles = ereq; v.exp_cycles = ecyc;
        v.exp_load = eld; v.exp_mis = emis; v.exp_berr = eberr;
        return v;
    endfunction

    // Drives one access from an IDLE negedge and plays the memory side.
    task automatic do_access(input vec_t v);
        vec_t e;
        int   req_n, wait_n, cyc;
        logic accepted, done;
        i_Valid           = 1'b1;
        i_Load_Store_Type = v.ls_type;
        i_Addr            = v.addr;
        i_Store_Data      = v.sdata;
        sb_q.push_back(v);
        #1;
        check("stall_on_request", {31'd0, o_Stall}, 32'd1);
        req_n = 0; wait_n = 0; cyc = 0; accepted = 1'b0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge i_Clk);
            cyc++;
            if (o_Done) begin
                done         = 1'b1;
                i_Mem_Ready  = 1'b0;
                i_Mem_Rvalid = 1'b0;
                e = sb_q.pop_front();
                check("load_data",  o_Load_Data, e.exp_load);
                check("misaligned", {31'd0, o_Misaligned}, {31'd0, e.exp_mis});
                check("bus_error",  {31'd0, o_Bus_Error},  {31'd0, e.exp_berr});
                check("stall_in_done", {31'd0, o_Stall}, 32'd0);
                check("req_in_done",   {31'd0, o_Mem_Req}, 32'd0);
                check("req_cycles",  32'(req_n), 32'(e.exp_req_cycles));
                check("latency",     32'(cyc),   32'(e.exp_cycles));
            end else if (o_Mem_Req) begin
                req_n++;
                if (req_n == 1) begin
                    check("mem_addr",  o_Mem_Addr, v.exp_addr);
                    check("mem_be",    {28'd0, o_Mem_Byte_En}, {28'd0, v.exp_be});
                    check("mem_we",    {31'd0, o_Mem_We}, {31'd0, v.exp_we});
                    if (v.exp_we) check("mem_wdata", o_Mem_Wdata, v.exp_wdata);
                end
                check("stall_in_req", {31'd0, o_Stall}, 32'd1);
                i_Mem_Ready  = (req_n > v.ready_wait);
                accepted     = i_Mem_Ready;
                i_Mem_Rvalid = 1'b0;
            end else begin
                i_Mem_Ready = 1'b0;
                if (accepted) begin
                    wait_n++;
                    i_Mem_Rvalid = (wait_n > v.rvalid_wait);
                    i_Mem_Rdata  = i_Mem_Rvalid ? v.rdata : 32'h5A5A5A5A;
                end
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL done_timeout: got no o_Done in %0d cycles, expected %0d", cyc, v.exp_cycles);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        i_Valid           = 1'b0;
        i_Load_Store_Type = c_NONE;
        i_Mem_Ready       = 1'b0;
        i_Mem_Rvalid      = 1'b0;
        @(negedge i_Clk);
        check("done_one_cycle", {31'd0, o_Done}, 32'd0);
        check("flags_clear",    {30'd0, o_Misaligned, o_Bus_Error}, 32'd0);
        check("load_data_hold", o_Load_Data, v.exp_load);
        check("stall_idle",     {31'd0, o_Stall}, 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(c_SW,  32'h100, 32'hDEADBEEF, 32'h0,        2,   0,   32'h100, 4'b1111, 32'hDEADBEEF, 1'b1, 3, 4,  32'h0,        1'b0, 1'b0);
        vecs[1]  = mk(c_SB,  32'h103, 32'h000000A5, 32'h0,        0,   0,   32'h100, 4'b1000, 32'hA5A5A5A5, 1'b1, 1, 2,  32'h0,        1'b0, 1'b0);
        vecs[2]  = mk(c_LB,  32'h102, 32'h0,        32'h1280FF00, 0,   0,   32'h100, 4'b1111, 32'h0,        1'b0, 1, 3,  32'hFFFFFF80, 1'b0, 1'b0);
        vecs[3]  = mk(c_LBU, 32'h102, 32'h0,        32'h1280FF00, 0,   0,   32'h100, 4'b1111, 32'h0,        1'b0, 1, 3,  32'h00000080, 1'b0, 1'b0);
        vecs[4]  = mk(c_LH,  32'h102, 32'h0,        32'h1280FF00, 0,   0,   32'h100, 4'b1111, 32'h0,        1'b0, 1, 3,  32'h00001280, 1'b0, 1'b0);
        vecs[5]  = mk(c_LH,  32'h101, 32'h0,        32'h0,        0,   0,   32'h0,   4'b0000, 32'h0,        1'b0, 0, 1,  32'h0,        1'b1, 1'b0);
        vecs[6]  = mk(c_SH,  32'h202, 32'h1234BEEF, 32'h0,        1,   0,   32'h200, 4'b1100, 32'hBEEFBEEF, 1'b1, 2, 3,  32'h0,        1'b0, 1'b0);
        vecs[7]  = mk(c_LW,  32'h304, 32'h0,        32'hCAFEF00D, 0,   2,   32'h304, 4'b1111, 32'h0,        1'b0, 1, 5,  32'hCAFEF00D, 1'b0, 1'b0);
        vecs[8]  = mk(c_SB,  32'h001, 32'h0000005A, 32'h0,        0,   0,   32'h000, 4'b0010, 32'h5A5A5A5A, 1'b1, 1, 2,  32'h0,        1'b0, 1'b0);
        vecs[9]  = mk(c_LHU, 32'h300, 32'h0,        32'h1234F00D, 0,   0,   32'h300, 4'b1111, 32'h0,        1'b0, 1, 3,  32'h0000F00D, 1'b0, 1'b0);
        vecs[10] = mk(c_LB,  32'h101, 32'h0,        32'h00007F00, 0,   1,   32'h100, 4'b1111, 32'h0,        1'b0, 1, 4,  32'h0000007F, 1'b0, 1'b0);
        vecs[11] = mk(c_SW,  32'h102, 32'h11111111, 32'h0,        0,   0,   32'h0,   4'b0000, 32'h0,        1'b1, 0, 1,  32'h0,        1'b1, 1'b0);
        vecs[12] = mk(c_LW,  32'h500, 32'h0,        32'h0,        100, 0,   32'h500, 4'b1111, 32'h0,        1'b0, 8, 9,  32'h0,        1'b0, 1'b1);
        vecs[13] = mk(c_LW,  32'h504, 32'h0,        32'h89ABCDEF, 7,   0,   32'h504, 4'b1111, 32'h0,        1'b0, 8, 10, 32'h89ABCDEF, 1'b0, 1'b0);
        vecs[14] = mk(c_LW,  32'h508, 32'h0,        32'h0,        0,   100, 32'h508, 4'b1111, 32'h0,        1'b0, 1, 9,  32'h0,        1'b0, 1'b1);

        i_Reset = 1'b1; i_Valid = 1'b0; i_Load_Store_Type = c_NONE;
        i_Addr = 32'h0; i_Store_Data = 32'h0;
        i_Mem_Ready = 1'b0; i_Mem_Rvalid = 1'b0; i_Mem_Rdata = 32'h0;
        repeat (2) @(negedge i_Clk);
        check("reset_outputs", {o_Stall, o_Done, o_Misaligned, o_Bus_Error, o_Mem_Req, o_Mem_We, 26'd0},
              32'd0);
        check("reset_load_data", o_Load_Data, 32'd0);
        check("reset_mem_addr",  o_Mem_Addr,  32'd0);
        i_Reset = 1'b0;
        @(negedge i_Clk);

        // No qualifying request: NONE type with valid, and a load without valid.
        i_Valid = 1'b1; i_Load_Store_Type = c_NONE; #1;
        check("stall_type_none", {31'd0, o_Stall}, 32'd0);
        i_Valid = 1'b0; i_Load_Store_Type = c_LW; #1;
        check("stall_no_valid", {31'd0, o_Stall}, 32'd0);
        @(negedge i_Clk);
        check("no_req_when_idle", {31'd0, o_Mem_Req}, 32'd0);
        i_Load_Store_Type = c_NONE;

        for (int i = 0; i < c_NVEC; i++) do_access(vecs[i]);

        // Reset asserted while a load waits for its response.
        i_Valid = 1'b1; i_Load_Store_Type = c_LW; i_Addr = 32'h400;
        @(negedge i_Clk);
        check("rst_seq_req", {31'd0, o_Mem_Req}, 32'd1);
        i_Mem_Ready = 1'b1;
        @(negedge i_Clk);
        i_Mem_Ready = 1'b0;
        check("rst_seq_wait_stall", {30'd0, o_Stall, o_Mem_Req}, 32'd2);
        #2 i_Reset = 1'b1;
        #1;
        check("rst_async_stall", {31'd0, o_Stall}, 32'd0);
        check("rst_async_addr",  o_Mem_Addr, 32'd0);
        check("rst_async_be",    {28'd0, o_Mem_Byte_En}, 32'd0);
        check("rst_async_flags", {o_Done, o_Mem_Req, o_Misaligned, o_Bus_Error, 28'd0}, 32'd0);
        i_Valid = 1'b0; i_Load_Store_Type = c_NONE;
        @(negedge i_Clk);
        i_Reset = 1'b0;
        i_Mem_Rvalid = 1'b1; i_Mem_Rdata = 32'hFFFFFFFF;
        @(negedge i_Clk);
        i_Mem_Rvalid = 1'b0;
        check("late_rvalid_done", {31'd0, o_Done}, 32'd0);
        check("late_rvalid_data", o_Load_Data, 32'd0);
        @(negedge i_Clk);
        check("late_rvalid_done2", {31'd0, o_Done}, 32'd0);

        do_access(mk(c_SW, 32'h200, 32'h0BADF00D, 32'h0, 0, 0, 32'h200, 4'b1111, 32'h0BADF00D,
                     1'b1, 1, 2, 32'h0, 1'b0, 1'b0));

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
